// File: rtl/bubble_sort_pkg.sv
// Shared definitions for the bubble-sort controller and its companion ALU:
// operation codes, controller state encoding and default widths.
package bubble_sort_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   localparam logic [1:0] ALU_ADD     = 2'b00;
   localparam logic [1:0] ALU_SUB     = 2'b01;
   localparam logic [1:0] ALU_ADD_1   = 2'b10;
   localparam logic [1:0] ALU_COMPARE = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_RD_A  = 4'd1,
      ST_RD_B  = 4'd2,
      ST_CAP_B = 4'd3,
      ST_CMP   = 4'd4,
      ST_WR_A  = 4'd5,
      ST_WR_B  = 4'd6,
      ST_NEXT  = 4'd7,
      ST_DONE  = 4'd8
   } state_e;

endpackage

// File: rtl/bubble_sort_ctrl.sv
// In-place ascending bubble sort sequencer: reads adjacent pairs from a
// synchronous memory, compares them through an external ALU, swaps when needed.
//
// state  | meaning
// IDLE   | waiting for start; latches length and clears counters
// RD_A   | read element j
// RD_B   | read element j+1, capture element j into reg_a
// CAP_B  | capture element j+1 into reg_b
// CMP    | ALU compare of reg_a and reg_b
// WR_A   | write reg_b to address j
// WR_B   | write reg_a to address j+1, count the swap
// NEXT   | advance j, or close the pass (early exit when nothing swapped)
// DONE   | one-cycle completion pulse
module bubble_sort_ctrl
   import bubble_sort_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   num_elems,
   output logic              busy,
   output logic              done,
   output logic [15:0]       swap_cnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic [1:0]        alu_sel,
   output logic [DATA_W-1:0] alu_in_1,
   output logic [DATA_W-1:0] alu_in_2,
   input  logic              alu_lt,
   input  logic              alu_eq,
   input  logic              alu_gt
);

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] LEN_TWO = (ADDR_W+1)'(2);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [DATA_W-1:0]   r_reg_a;
   logic [DATA_W-1:0]   r_reg_b;
   logic [ADDR_W:0]     r_j;
   logic [ADDR_W:0]     r_limit;
   logic                r_swapped;
   logic [15:0]         r_swap_cnt;

   logic [ADDR_W:0]     w_limit_in;
   logic [ADDR_W:0]     w_j_inc;
   logic [ADDR_W:0]     w_lim_m1;
   logic                w_pass_more;
   logic                w_sort_end;
   logic                w_cmp_swap;

   assign w_limit_in  = (num_elems > MAX_LEN) ? MAX_LEN : num_elems;
   assign w_j_inc     = r_j + LEN_ONE;
   assign w_lim_m1    = r_limit - LEN_ONE;
   assign w_pass_more = (w_j_inc < w_lim_m1);
   assign w_sort_end  = !r_swapped || (r_limit == LEN_TWO);
   // A malformed flag set (none or several) is treated as "no swap" so memory is never disturbed.
   assign w_cmp_swap  = alu_gt && !(alu_lt || alu_eq);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = (w_limit_in < LEN_TWO) ? ST_DONE : ST_RD_A;
            end
         end
         ST_RD_A:  w_state_nxt = ST_RD_B;
         ST_RD_B:  w_state_nxt = ST_CAP_B;
         ST_CAP_B: w_state_nxt = ST_CMP;
         ST_CMP:   w_state_nxt = w_cmp_swap ? ST_WR_A : ST_NEXT;
         ST_WR_A:  w_state_nxt = ST_WR_B;
         ST_WR_B:  w_state_nxt = ST_NEXT;
         ST_NEXT: begin
            if (w_pass_more) begin
               w_state_nxt = ST_RD_A;
            end else if (w_sort_end) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_RD_A;
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg_a    <= '0;
         r_reg_b    <= '0;
         r_j        <= '0;
         r_limit    <= '0;
         r_swapped  <= 1'b0;
         r_swap_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_limit    <= w_limit_in;
                  r_swap_cnt <= '0;
                  r_j        <= '0;
                  r_swapped  <= 1'b0;
               end
            end
            ST_RD_B:  r_reg_a <= mem_rd_data;
            ST_CAP_B: r_reg_b <= mem_rd_data;
            ST_WR_B: begin
               r_swapped <= 1'b1;
               if (r_swap_cnt != 16'hFFFF) begin
                  r_swap_cnt <= r_swap_cnt + 16'd1;
               end
            end
            ST_NEXT: begin
               if (w_pass_more) begin
                  r_j <= w_j_inc;
               end else if (!w_sort_end) begin
                  // The largest remaining element has settled at the tail; shrink the pass.
                  r_limit   <= w_lim_m1;
                  r_j       <= '0;
                  r_swapped <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy        = (r_state != ST_IDLE);
      done        = 1'b0;
      mem_addr    = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      alu_sel     = ALU_ADD;
      case (r_state)
         ST_RD_A: begin
            mem_addr  = r_j[ADDR_W-1:0];
            mem_rd_en = 1'b1;
         end
         ST_RD_B: begin
            mem_addr  = w_j_inc[ADDR_W-1:0];
            mem_rd_en = 1'b1;
         end
         ST_CMP:  alu_sel = ALU_COMPARE;
         ST_WR_A: begin
            mem_addr    = r_j[ADDR_W-1:0];
            mem_wr_en   = 1'b1;
            mem_wr_data = r_reg_b;
         end
         ST_WR_B: begin
            mem_addr    = w_j_inc[ADDR_W-1:0];
            mem_wr_en   = 1'b1;
            mem_wr_data = r_reg_a;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign swap_cnt = r_swap_cnt;
   assign alu_in_1 = r_reg_a;
   assign alu_in_2 = r_reg_b;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl with a behavioural memory and compare ALU.
module tb_bubble_sort_ctrl;
   import bubble_sort_pkg::*;

   localparam int DW = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW:0]   num_elems;
   logic          busy;
   logic          done;
   logic [15:0]   swap_cnt;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [DW-1:0] mem_rd_data;
   logic          mem_wr_en;
   logic [DW-1:0] mem_wr_data;
   logic [1:0]    alu_sel;
   logic [DW-1:0] alu_in_1;
   logic [DW-1:0] alu_in_2;
   logic          alu_lt, alu_eq, alu_gt;

   logic [DW-1:0] mem [16];
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   int done_cyc, wr_cnt, rd_cnt, cmp_cnt, alu_bad;
   int after_done, after_busy;
   int wr_addr_log [8];
   int wr_data_log [8];

   always #5 clk = ~clk;

   bubble_sort_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .num_elems(num_elems),
      .busy(busy), .done(done), .swap_cnt(swap_cnt),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
      .alu_sel(alu_sel), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
      .alu_lt(alu_lt), .alu_eq(alu_eq), .alu_gt(alu_gt)
   );

   assign alu_lt = (alu_sel == ALU_COMPARE) && (alu_in_1 <  alu_in_2);
   assign alu_eq = (alu_sel == ALU_COMPARE) && (alu_in_1 == alu_in_2);
   assign alu_gt = (alu_sel == ALU_COMPARE) && (alu_in_1 >  alu_in_2);

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int idx, input logic [DW-1:0] v);
      ld_en   = 1'b1;
      ld_addr = AW'(idx);
      ld_data = v;
      tick();
      ld_en   = 1'b0;
   endtask

   // Start a sort and observe it cycle by cycle; cycle 1 is the first after the start edge.
   task automatic run_sort(input logic [AW:0] n, input int mid_start);
      done_cyc = -1; wr_cnt = 0; rd_cnt = 0; cmp_cnt = 0; alu_bad = 0;
      num_elems = n;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 3000; c++) begin
         if (c == mid_start) begin
            start = 1'b1;
            num_elems = 5'd2;
         end else begin
            start = 1'b0;
         end
         if (mem_wr_en) begin
            if (wr_cnt < 8) begin
               wr_addr_log[wr_cnt] = int'(mem_addr);
               wr_data_log[wr_cnt] = int'(mem_wr_data);
            end
            wr_cnt++;
         end
         if (mem_rd_en) rd_cnt++;
         if (alu_sel == ALU_COMPARE) begin
            cmp_cnt++;
            if (mem_rd_en || mem_wr_en) alu_bad++;
         end else if (alu_sel != ALU_ADD) begin
            alu_bad++;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
         tick();
      end
      start = 1'b0;
      tick();
      after_done = int'(done);
      after_busy = int'(busy);
   endtask

   initial begin
      int bad;
      int found;
      rst = 1'b1; start = 1'b0; num_elems = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_swap_cnt", swap_cnt, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_strobes", {mem_rd_en, mem_wr_en}, 0);
      check("rst_wr_data", mem_wr_data, 0);
      check("rst_alu_sel", alu_sel, 0);
      rst = 1'b0;
      tick();

      load(0, 16'd5); load(1, 16'd9);
      run_sort(5'd2, 0);
      check("s59_done_cyc", done_cyc, 6);
      check("s59_writes", wr_cnt, 0);
      check("s59_swaps", swap_cnt, 0);
      check("s59_mem", {mem[0], mem[1]}, {16'd5, 16'd9});
      check("s59_pulse", {after_done[0], after_busy[0]}, 0);

      load(0, 16'd9); load(1, 16'd5);
      run_sort(5'd2, 0);
      check("s95_done_cyc", done_cyc, 8);
      check("s95_writes", wr_cnt, 2);
      check("s95_wrA", {wr_addr_log[0][15:0], wr_data_log[0][15:0]}, {16'd0, 16'd5});
      check("s95_wrB", {wr_addr_log[1][15:0], wr_data_log[1][15:0]}, {16'd1, 16'd9});
      check("s95_swaps", swap_cnt, 1);

      load(0, 16'd4); load(1, 16'd3); load(2, 16'd2); load(3, 16'd1);
      run_sort(5'd4, 0);
      check("s4321_mem_lo", {mem[0], mem[1]}, {16'd1, 16'd2});
      check("s4321_mem_hi", {mem[2], mem[3]}, {16'd3, 16'd4});
      check("s4321_swaps", swap_cnt, 6);
      check("s4321_compares", cmp_cnt, 6);
      check("s4321_alu_sel_only_cmp", alu_bad, 0);
      check("s4321_done_cyc", done_cyc, 43);

      run_sort(5'd1, 0);
      check("n1_done_by_t2", (done_cyc >= 1) && (done_cyc <= 2), 1);
      check("n1_no_access", rd_cnt + wr_cnt, 0);
      check("n1_swap_cleared", swap_cnt, 0);

      run_sort(5'd0, 0);
      check("n0_done_by_t2", (done_cyc >= 1) && (done_cyc <= 2), 1);
      check("n0_no_access", rd_cnt + wr_cnt, 0);

      run_sort(5'd4, 0);
      check("s1234_done_cyc", done_cyc, 16);
      check("s1234_writes", wr_cnt, 0);
      check("s1234_compares", cmp_cnt, 3);

      for (int i = 0; i < 16; i++) load(i, DW'(16 - i));
      run_sort(5'd17, 0);
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== DW'(i + 1)) bad++;
      check("clamp17_unsorted_slots", bad, 0);
      check("clamp17_swaps", swap_cnt, 120);
      check("clamp17_done_cyc", done_cyc, 841);

      load(0, 16'd7); load(1, 16'd7); load(2, 16'd3);
      run_sort(5'd3, 0);
      check("s773_mem", {mem[0], mem[1], mem[2]}, {16'd3, 16'd7, 16'd7});
      check("s773_swaps", swap_cnt, 2);
      check("s773_done_cyc", done_cyc, 20);

      load(0, 16'd3); load(1, 16'd2); load(2, 16'd1);
      run_sort(5'd3, 4);
      check("busy_start_done_cyc", done_cyc, 22);
      check("busy_start_swaps", swap_cnt, 3);
      check("busy_start_mem", {mem[0], mem[1], mem[2]}, {16'd1, 16'd2, 16'd3});

      load(0, 16'd9); load(1, 16'd5);
      num_elems = 5'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 20; c++) begin
         if (mem_wr_en) begin
            found = 1;
            break;
         end
         tick();
      end
      check("rst_mid_reached_wr_a", found, 1);
      rst = 1'b1;
      tick();
      check("rst_mid_idle", {busy, done, mem_wr_en}, 0);
      check("rst_mid_swap_cnt", swap_cnt, 0);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         if (mem_wr_en || busy) bad++;
         tick();
      end
      check("rst_mid_quiet", bad, 0);
      check("rst_mid_mem", {mem[0], mem[1]}, {16'd5, 16'd5});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bubble_sort_ctrl.md
Name: bubble_sort_ctrl

Overview:
- Control unit for the bubble-sort datapath. It sequences reads and writes of the data memory and drives the ALU in COMPARE mode.
- It consumes the ALU's lt/eq/gt flags to decide swaps, and sorts the array in place in ascending order.
- It sits beside the ALU at the top level: the ALU is instantiated by the top level, not inside this block.
- It terminates early after any pass with no swaps.

Parameters:
- DATA_W, 16: element width; must match the ALU data_in_width.
- ADDR_W, 4: memory address width. Maximum array length is 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin sorting; sampled only in IDLE.
- num_elems  in  ADDR_W+1  array length, sampled with start. Values above 2**ADDR_W are clamped to 2**ADDR_W.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when sorting completes.
- swap_cnt  out  16  swaps performed in the current or last sort; saturates at 16'hFFFF.
- mem_addr  out  ADDR_W  memory address.
- mem_rd_en  out  1  read strobe; data returns on mem_rd_data one cycle later.
- mem_rd_data  in  DATA_W  synchronous read data.
- mem_wr_en  out  1  write strobe; write occurs at the clock edge.
- mem_wr_data  out  DATA_W  write data.
- alu_sel  out  2  ALU operation select.
- alu_in_1  out  DATA_W  equals reg_a at all times.
- alu_in_2  out  DATA_W  equals reg_b at all times.
- alu_lt, alu_eq, alu_gt  in  1 each  ALU comparison flags, valid combinationally when alu_sel=COMPARE.

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, swap_cnt=0, mem_addr=0, mem_rd_en=0, mem_wr_en=0, mem_wr_data=0, alu_sel=2'b00; internal reg_a, reg_b, j, limit, swapped all 0.
- Reset mid-operation returns to IDLE in the next cycle. No further writes occur; memory may be left partially sorted.
- ALU codes: ADD=00, SUB=01, ADD_1=10, COMPARE=11. alu_sel=COMPARE only in CMP, 00 otherwise.
- All strobes are registered-state decodes (Moore).
- IDLE:
  - On start, latch limit=clamp(num_elems), clear swap_cnt, j=0, swapped=0.
  - If limit<2, go to DONE; else go to RD_A.
- RD_A: mem_addr=j, mem_rd_en=1.
- RD_B: mem_addr=j+1, mem_rd_en=1; reg_a<=mem_rd_data.
- CAP_B: reg_b<=mem_rd_data.
- CMP: alu_sel=COMPARE.
  - alu_gt=1: go to WR_A.
  - alu_lt or alu_eq: go to NEXT. Equal elements are never swapped, so the sort is stable.
- WR_A: mem_addr=j, mem_wr_en=1, mem_wr_data=reg_b.
- WR_B: mem_addr=j+1, mem_wr_en=1, mem_wr_data=reg_a; swapped<=1; swap_cnt++ (saturating). Go to NEXT.
- NEXT:
  - If j+1 < limit-1: j++, go to RD_A.
  - Else (end of pass): if swapped=0 or limit=2, go to DONE. Otherwise limit--, j=0, swapped=0, go to RD_A.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- start asserted while busy is ignored; no queuing.
- Width rules:
  - j and limit are ADDR_W+1 bits, so limit=2**ADDR_W does not wrap.
  - mem_addr uses the low ADDR_W bits of j and j+1; j+1 ≤ 2**ADDR_W-1 always.
- Timing:
  - A non-swapping pair costs 5 cycles (RD_A..NEXT); a swapping pair costs 7.
  - With start sampled at edge t0, RD_A is the state in cycle t1.

Decomposition:
- Shared package bubble_sort_pkg holds:
  - ALU_sel code constants, also to be used by the ALU.
  - The state encoding (IDLE, RD_A, RD_B, CAP_B, CMP, WR_A, WR_B, NEXT, DONE; 4-bit).
  - DATA_W and ADDR_W defaults.
- No sub-module inside this block. The top level wires bubble_sort_ctrl, ALU and the memory.

Test Plan:
- num_elems=2, mem=[5,9], start at t0: no write strobes; done=1 in cycle t6; swap_cnt=0; memory unchanged.
- num_elems=2, mem=[9,5]: WR_A writes addr0=5, WR_B writes addr1=9; done in cycle t8; swap_cnt=1.
- num_elems=4, mem=[4,3,2,1]: final mem=[1,2,3,4]; swap_cnt=6; alu_sel=11 only during CMP cycles.
- num_elems=4, mem=[1,2,3,4]: single pass, no writes; done in cycle t16; swap_cnt=0.
- num_elems=1 and num_elems=0: done in cycle t2 with no memory access. num_elems=17 with ADDR_W=4: clamped to 16, and all 16 elements sorted.
- Equal keys, mem=[7,7,3]: final [3,7,7]; swap_cnt=2. rst pulsed mid-WR_A: state IDLE next cycle, busy=0, no further mem_wr_en. start during busy: ignored.
